// File: rtl/lab2_serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout, S} = A + B + cin, one full-adder slice per clock,
// LSB first. A start/busy/done handshake lets operations be issued back-to-back.
module lab2_serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only the upper WIDTH-1 partial-sum bits need storing; the newest bit enters at the top.
  logic [WIDTH-1:1] r_sh_q, r_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] sum_next;

  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_nxt    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  assign sum_next = {s_bit, r_sh_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    c_d     = c_q;
    count_d = count_q;
    s_d     = s_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          c_d     = cin;
          r_sh_d  = '0;
          count_d = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        c_d     = c_nxt;
        r_sh_d  = sum_next[WIDTH-1:1];
        count_d = count_q + CW'(1);
        if (count_q == LastCnt) begin
          s_d     = sum_next;
          cout_d  = c_nxt;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      c_q     <= 1'b0;
      count_q <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      c_q     <= c_d;
      count_q <= count_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign S    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_lab2_serial_adder.sv
// Scoreboard bench for lab2_serial_adder: stimulus pushes expected {cout,S}, a monitor pops
// and compares on every done pulse and checks that S/cout hold steady between completions.
module tb_lab2_serial_adder;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] S;
  logic             cout;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] held_exp = '0;

  lab2_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .S    (S),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge, away from stimulus at negedge.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rst !== 1'b1) begin
        if (done === 1'b1) begin
          done_cnt++;
          check("busy_done_exclusive", {31'd0, busy}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", {27'd0, cout, S}, {27'd0, e});
            held_exp = e;
          end
        end else begin
          check("result_held", {27'd0, cout, S}, {27'd0, held_exp});
        end
      end
    end
  end

  // Wait for done, counting negedges since the one just after acceptance; returns busy count.
  task automatic wait_done(output int n, output int busy_seen);
    n = 0;
    busy_seen = 0;
    while (done !== 1'b1 && n < 4 * WIDTH) begin
      if (busy === 1'b1) busy_seen++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [WIDTH:0] req, input string name);
    int n, bs;
    @(negedge clk);
    A = a; B = b; cin = ci; start = 1'b1;
    exp_q.push_back(req);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bs);
    check({name, "_latency"}, n, WIDTH);
    check({name, "_busy_cycles"}, bs, WIDTH);
    @(negedge clk);
  endtask

  initial begin
    int n, bs, d0;
    logic [WIDTH:0] model;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {26'd0, busy, done, cout, S}, 32'd0);
    rst = 1'b0;

    // 1..3: directed vectors
    run_op(4'b0000, 4'b1100, 1'b1, 5'b0_1101, "t1");
    run_op(4'b0101, 4'b1011, 1'b0, 5'b1_0000, "t2a");
    run_op(4'b1111, 4'b1111, 1'b1, 5'b1_1111, "t2b");
    run_op(4'b0101, 4'b0010, 1'b0, 5'b0_0111, "t3_loopback");
    check("idle_after_op", {30'd0, busy, done}, 32'd0);

    // 4: start pulsed mid-run is ignored
    d0 = done_cnt;
    @(negedge clk);
    A = 4'b0011; B = 4'b0100; cin = 1'b0; start = 1'b1;
    exp_q.push_back(5'b0_0111);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 4'b1000; B = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bs);
    repeat (WIDTH + 2) @(negedge clk);
    check("t4_single_done", done_cnt - d0, 1);
    check("t4_idle", {30'd0, busy, done}, 32'd0);

    // 5: start held through DONE reloads immediately
    @(negedge clk);
    A = 4'b0001; B = 4'b0001; cin = 1'b1; start = 1'b1;
    exp_q.push_back(5'b0_0011);
    @(negedge clk);
    A = 4'b1011; B = 4'b0110; cin = 1'b0;
    exp_q.push_back(5'b1_0001);
    wait_done(n, bs);
    check("t5_first_latency", n, WIDTH);
    @(negedge clk);
    start = 1'b0;
    check("t5_no_idle_gap", {31'd0, busy}, 32'd1);
    wait_done(n, bs);
    check("t5_back_to_back_period", n + 1, WIDTH + 1);
    @(negedge clk);

    // 6: reset mid-run aborts without a done pulse
    d0 = done_cnt;
    A = 4'b0111; B = 4'b0111; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    held_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_reset_outputs", {26'd0, busy, done, cout, S}, 32'd0);
    repeat (WIDTH + 3) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    run_op(4'b1001, 4'b0011, 1'b1, 5'b0_1101, "t6_fresh");

    // Exhaustive sweep against A+B+cin
    for (int i = 0; i < 512; i++) begin
      model = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'd0, i[8]};
      run_op(i[3:0], i[7:4], i[8], model, "sweep");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
